// File: rtl/round_seq_pkg.sv
// Shared definitions for the round sequencer: FSM state encoding and default
// round/stage counts.
package round_seq_pkg;

   localparam int unsigned NUM_ROUNDS_DEF = 24;
   localparam int unsigned NUM_STAGES_DEF = 5;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT   = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/round_stage_counter.sv
// Nested stage/round counter: stage wraps after the last stage and bumps the
// round; the round count is latched (and clamped) when the counter is initialised.
module round_stage_counter
   import round_seq_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
   parameter int unsigned ROUND_W    = $clog2(NUM_ROUNDS + 1),
   parameter int unsigned STAGE_W    = idx_width(NUM_STAGES)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic [ROUND_W-1:0] num_rounds,
   input  logic               advance,
   output logic [STAGE_W-1:0] stage,
   output logic [STAGE_W-1:0] stage_nxt,
   output logic [ROUND_W-1:0] round,
   output logic               last
);

   logic [ROUND_W-1:0] rounds_q;
   logic [ROUND_W-1:0] rounds_clamped;
   logic               stage_wrap;

   assign rounds_clamped = (num_rounds > ROUND_W'(NUM_ROUNDS)) ? ROUND_W'(NUM_ROUNDS) : num_rounds;
   assign stage_wrap     = (stage == STAGE_W'(NUM_STAGES - 1));
   assign stage_nxt      = stage_wrap ? '0 : stage + STAGE_W'(1);
   assign last           = stage_wrap && (round == rounds_q - ROUND_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage    <= '0;
         round    <= '0;
         rounds_q <= '0;
      end else if (init) begin
         stage    <= '0;
         round    <= '0;
         rounds_q <= rounds_clamped;
      end else if (advance) begin
         stage <= stage_nxt;
         if (stage_wrap) begin
            round <= round + ROUND_W'(1);
         end
      end
   end

endmodule

// File: rtl/round_sequencer.sv
// Round controller: issues one-hot stage start pulses round by round, with abort
// and done signalling. Optional per-stage watchdog under ROUND_SEQ_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | waiting for start; busy low
// ISSUE  | stage_start pulse for the current stage is on the outputs
// WAIT   | waiting for stage_ready of the current stage only
// FINISH | done pulse cycle; start still ignored here
module round_sequencer
   import round_seq_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS     = NUM_ROUNDS_DEF,
   parameter int unsigned NUM_STAGES     = NUM_STAGES_DEF,
   parameter int unsigned ROUND_W        = $clog2(NUM_ROUNDS + 1),
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ROUND_W-1:0]    num_rounds,
   input  logic                  abort,
   input  logic [NUM_STAGES-1:0] stage_ready,
   output logic [NUM_STAGES-1:0] stage_start,
   output logic [ROUND_W-1:0]    round,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned STAGE_W = idx_width(NUM_STAGES);

   state_t             state;
   logic [STAGE_W-1:0] stage;
   logic [STAGE_W-1:0] stage_nxt;
   logic               last;
   logic               init;
   logic               advance;
   logic               rdy_hit;
   logic               wd_expired;

   assign rdy_hit = stage_ready[stage];
   assign init    = (state == S_IDLE) && start;
   assign advance = (state == S_WAIT) && !abort && rdy_hit && !last;

   round_stage_counter #(
      .NUM_ROUNDS (NUM_ROUNDS),
      .NUM_STAGES (NUM_STAGES),
      .ROUND_W    (ROUND_W),
      .STAGE_W    (STAGE_W)
   ) u_counter (
      .clk        (clk),
      .rst        (rst),
      .init       (init),
      .num_rounds (num_rounds),
      .advance    (advance),
      .stage      (stage),
      .stage_nxt  (stage_nxt),
      .round      (round),
      .last       (last)
   );

`ifdef ROUND_SEQ_TIMEOUT_EN
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [WD_W-1:0] wd_cnt;

   // Down-counter reloaded while the start pulse is out; expiry is terminal count in WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
      end else if (state == S_ISSUE) begin
         wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
      end else if ((state == S_WAIT) && (wd_cnt != '0)) begin
         wd_cnt <= wd_cnt - WD_W'(1);
      end
   end

   assign wd_expired = (state == S_WAIT) && (wd_cnt == '0);
`else
   // Keeps the watchdog limit referenced when the watchdog is not built.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign wd_expired     = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         stage_start <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         stage_start <= '0;
         done        <= 1'b0;
         error       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_rounds == '0) begin
                     state <= S_FINISH;
                     done  <= 1'b1;
                  end else begin
                     state       <= S_ISSUE;
                     stage_start <= NUM_STAGES'(1);
                  end
               end
            end
            S_ISSUE: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (rdy_hit) begin
                  if (last) begin
                     state <= S_FINISH;
                     done  <= 1'b1;
                  end else begin
                     state       <= S_ISSUE;
                     stage_start <= NUM_STAGES'(1) << stage_nxt;
                  end
               end else if (wd_expired) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  error <= 1'b1;
               end
            end
            S_FINISH: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: stimulus pushes expected output events,
// a negedge monitor pops and compares each stage_start/done/error event.
module tb_round_sequencer;

   localparam int NS = 5;
   localparam int RW = 5;

   logic          clk;
   logic          rst;
   logic          start;
   logic [RW-1:0] num_rounds;
   logic          abort;
   logic [NS-1:0] stage_ready;
   logic [NS-1:0] stage_start;
   logic [RW-1:0] round;
   logic          busy;
   logic          done;
   logic          error;

   round_sequencer #(
      .NUM_ROUNDS     (24),
      .NUM_STAGES     (NS),
      .ROUND_W        (RW),
      .TIMEOUT_CYCLES (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_rounds  (num_rounds),
      .abort       (abort),
      .stage_ready (stage_ready),
      .stage_start (stage_start),
      .round       (round),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   typedef struct {
      int cyc;
      int kind;   // 0..NS-1 stage start, 5 done, 6 error
      int rnd;
   } ev_t;

   ev_t           exp_q[$];
   int            vectors     = 0;
   int            miscompares = 0;
   int            cyc         = 0;
   logic [NS-1:0] inject      = '0;
   logic [NS-1:0] hold_mask   = '0;
   logic [NS-1:0] last_ss     = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input int k, input int r);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      e.rnd  = r;
      exp_q.push_back(e);
   endtask

   // Every stage answers one cycle after its start: stage j of round r at t+1+2(5r+j).
   task automatic push_run(input int t, input int nr);
      int n;
      n = (nr > 24) ? 24 : nr;
      for (int k = 0; k < 5 * n; k++) push_ev(t + 1 + 2 * k, k % 5, k / 5);
      push_ev(t + 1 + 10 * n, 5, (n == 0) ? 0 : n - 1);
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Stage engine model: ready one cycle after each start, unless withheld.
   always @(posedge clk) begin
      #2;
      stage_ready = (last_ss & ~hold_mask) | inject;
      last_ss     = stage_start;
   end

   // Monitor
   always @(negedge clk) begin
      int  obs;
      ev_t e;
      if (stage_start != '0 || done || error) begin
         obs = 6;
         if (stage_start != '0) begin
            for (int i = 0; i < NS; i++) if (stage_start[i]) obs = i;
            chk("stage_start_onehot", int'($onehot(stage_start)), 1);
         end else if (done) begin
            obs = 5;
         end
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: kind %0d round %0d at cycle %0d, required none", obs, round, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("event_kind", obs, e.kind);
            chk("event_round", int'(round), e.rnd);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: bench still running at cycle %0d, required finish", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      int t;
      start      = 1'b0;
      num_rounds = '0;
      abort      = 1'b0;
      rst        = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("reset_stage_start", int'(stage_start), 0);
      chk("reset_round", int'(round), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_error", int'(error), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Full 24-round run with ignored starts mid-run and in the done cycle,
      // then a clamped 31-round run started the cycle after done.
      t = cyc + 2;
      goto(t);
      start = 1'b1; num_rounds = 24; push_run(t, 24);
      goto(t + 1);   start = 1'b0;
      goto(t + 50);  start = 1'b1; num_rounds = 3;
      goto(t + 51);  start = 1'b0;
      goto(t + 241);
      chk("busy_in_done_cycle", int'(busy), 1);
      start = 1'b1; num_rounds = 2;
      goto(t + 242);
      chk("busy_after_done", int'(busy), 0);
      start = 1'b1; num_rounds = 31; push_run(t + 242, 24);
      goto(t + 243); start = 1'b0;
      goto(t + 484);
      chk("busy_after_clamped_run", int'(busy), 0);

      // Zero rounds: done straight away, no stage pulses.
      t = cyc + 2;
      goto(t);
      start = 1'b1; num_rounds = 0; push_run(t, 0);
      goto(t + 1); start = 1'b0;
      chk("busy_zero_rounds_finish", int'(busy), 1);
      goto(t + 2);
      chk("busy_zero_rounds_idle", int'(busy), 0);

      // Single round.
      t = cyc + 2;
      goto(t);
      start = 1'b1; num_rounds = 1; push_run(t, 1);
      goto(t + 1); start = 1'b0;
      goto(t + 12);
      chk("busy_one_round_idle", int'(busy), 0);

      // Stage 1 withheld, spurious ready[3] and a mid-run start ignored.
      t = cyc + 2;
      goto(t);
      hold_mask = 5'b00010;
      start = 1'b1; num_rounds = 1;
      push_ev(t + 1, 0, 0);
      push_ev(t + 3, 1, 0);
      push_ev(t + 7, 2, 0);
      push_ev(t + 9, 3, 0);
      push_ev(t + 11, 4, 0);
      push_ev(t + 13, 5, 0);
      goto(t + 1); start = 1'b0;
      goto(t + 4); inject = 5'b01000;
      goto(t + 5); start = 1'b1; num_rounds = 2;
      goto(t + 6); start = 1'b0; inject = 5'b00010;
      goto(t + 7); inject = '0; hold_mask = '0;
      goto(t + 14);
      chk("busy_spurious_idle", int'(busy), 0);

      // Abort in round 5 while waiting on stage 2, racing its ready.
      t = cyc + 2;
      goto(t);
      start = 1'b1; num_rounds = 24;
      for (int k = 0; k < 28; k++) push_ev(t + 1 + 2 * k, k % 5, k / 5);
      goto(t + 1);  start = 1'b0;
      goto(t + 56); abort = 1'b1;
      goto(t + 57); abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_round", int'(round), 5);
      chk("abort_stage_start", int'(stage_start), 0);
      goto(t + 80);

      // Asynchronous reset mid-run.
      t = cyc + 2;
      goto(t);
      start = 1'b1; num_rounds = 24;
      for (int k = 0; k < 5; k++) push_ev(t + 1 + 2 * k, k, 0);
      goto(t + 1); start = 1'b0;
      goto(t + 11);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_stage_start", int'(stage_start), 0);
      chk("async_rst_round", int'(round), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_done", int'(done), 0);
      goto(t + 13); rst = 1'b0;
      goto(t + 33);
      chk("busy_after_rst", int'(busy), 0);

      // Stage 0 never answers.
      t = cyc + 2;
      goto(t);
      hold_mask = 5'b00001;
      start = 1'b1; num_rounds = 1;
      push_ev(t + 1, 0, 0);
`ifdef ROUND_SEQ_TIMEOUT_EN
      push_ev(t + 12, 6, 0);
      goto(t + 1); start = 1'b0;
      goto(t + 30);
      chk("busy_after_timeout", int'(busy), 0);
`else
      goto(t + 1); start = 1'b0;
      goto(t + 300);
      chk("busy_no_watchdog", int'(busy), 1);
      chk("error_no_watchdog", int'(error), 0);
      abort = 1'b1;
      goto(t + 301); abort = 1'b0;
      chk("busy_after_abort", int'(busy), 0);
`endif
      hold_mask = '0;

      goto(cyc + 5);
      chk("events_outstanding", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Parametrised round controller for the encoder datapath. On `start` it runs a programmable number of rounds. Each round is a fixed chain of `NUM_STAGES` stage engines (column parity, rotate, permute, revaluate, add-round-constant in the default build), each driven by a one-cycle start pulse and answered by a one-cycle ready pulse. It sits between the top-level controller and the stage engines, and replaces ad-hoc start chaining with one FSM, a round index, abort and completion signalling.

## Interface
- `NUM_ROUNDS`, 24: maximum and default round count.
- `NUM_STAGES`, 5: stages per round, issued in index order 0..NUM_STAGES-1.
- `ROUND_W`, $clog2(NUM_ROUNDS+1): width of round count/index.
- `TIMEOUT_CYCLES`, 255: per-stage watchdog limit; only used with `ROUND_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a run; accepted only in IDLE.
- `num_rounds`  in  ROUND_W  rounds to run, sampled when `start` is accepted.
- `abort`  in  1  cancel the run in progress.
- `stage_ready`  in  NUM_STAGES  one-cycle completion pulse per stage.
- `stage_start`  out  NUM_STAGES  registered one-hot start pulse per stage.
- `round`  out  ROUND_W  index of the current round, 0-based.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when all rounds are complete.
- `error`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- FSM states:
  - IDLE → ISSUE on `start`.
  - ISSUE → WAIT.
  - WAIT → ISSUE when the current stage's ready arrives and work remains.
  - WAIT → FINISH when the ready is for the last stage of the last round.
  - FINISH → IDLE.
- ISSUE drives `stage_start[stage]`=1 for exactly one cycle. All other cycles `stage_start`=0.
- In WAIT, only `stage_ready[stage]` is observed. Ready bits for other stages, and any ready seen in ISSUE or IDLE, are ignored.
- Stage/round advance:
  - After stage NUM_STAGES-1, `stage` wraps to 0 and `round` increments.
  - After the final round, `round` holds its last value until the next accepted `start` clears it to 0.
- `num_rounds` rules:
  - 0: IDLE → FINISH directly. `done` pulses with no stage pulses.
  - Greater than NUM_ROUNDS: clamped to NUM_ROUNDS.
- `start` while busy is ignored, including in the FINISH cycle.
- `abort` in any non-IDLE state returns the FSM to IDLE on the next edge.
  - `stage_start` and `done` are forced to 0 in that transition.
  - `round` keeps its value.
  - `abort` has priority over a simultaneous `stage_ready`.
- Reset values: `stage_start`=0, `round`=0, `busy`=0, `done`=0, `error`=0, state IDLE. Reset mid-run discards the run; no `done` is issued.

## Timing
- `start` accepted at cycle t → `stage_start[0]` at t+1.
- Current stage's ready at cycle c → next `stage_start` at c+1. Per-stage overhead is 1 cycle.
- Final ready at c → `done`=1 at c+1. `busy` drops at c+2.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `ROUND_SEQ_TIMEOUT_EN`.
- Defined:
  - An 8+-bit counter runs in WAIT and reloads in every ISSUE.
  - Reaching `TIMEOUT_CYCLES` with no valid ready moves the FSM to IDLE and pulses `error` for one cycle; no `done` is issued.
- Undefined: `error` is tied 0 and WAIT has no time limit.

## Structure
- Shared package `round_seq_pkg`: FSM state encoding (IDLE, ISSUE, WAIT, FINISH) and default round/stage counts.
- Sub-module `round_stage_counter`: a nested stage/round counter with init, enable, stage wrap, round increment and a last-stage/last-round flag.

## Test plan
Default parameters; every stage returns ready one cycle after its start.
- Reset, then `start` at cycle 0 with `num_rounds`=24:
  - Stage j of round r starts at cycle 1+2(5r+j).
  - `done` at cycle 241, `busy` low at cycle 242.
  - Exactly 120 `stage_start` pulses.
- `num_rounds`=0 → `done` at cycle 1 (start at 0), zero stage pulses. `num_rounds`=31 → behaves as 24.
- Boundary of round count: `num_rounds`=1 → 5 pulses, `done` at cycle 11, `round`=0 throughout.
- Spurious or overlapping requests:
  - Drive `stage_ready[3]` while waiting on stage 1 → ignored; order unchanged.
  - Assert `start` mid-run → ignored.
  - Assert `start` in the `done` cycle → ignored.
  - Assert `start` one cycle later → new run, `round` cleared to 0.
- Abort and reset mid-run:
  - `abort` in round 5 while WAITing on stage 2, with `stage_ready[2]` in the same cycle → IDLE next cycle, `round`=5, no `done`, no further pulses.
  - Asynchronous `rst` mid-run → all outputs 0 immediately.
- With `ROUND_SEQ_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10, withhold stage 0's ready → `error` pulse about 10 cycles after the stage start, then IDLE, no `done`. Without the macro, `busy` stays high indefinitely.
